// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command path (interpreter and ack
// transmitter): FSM states, ack frame framing bytes, command byte codes.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_SEND    = 3'd3,
        ST_DONE    = 3'd4
    } cmd_state_t;

    localparam int         ACK_FRAME_LEN = 7;
    localparam logic [2:0] ACK_LAST_IDX  = 3'(ACK_FRAME_LEN - 1);
    localparam logic [7:0] ACK_SOF       = 8'h21;
    localparam logic [7:0] ACK_EOF       = 8'h0D;

    localparam logic [7:0] CMD_MGU  = 8'h4D;
    localparam logic [7:0] CMD_GNU  = 8'h47;
    localparam logic [7:0] CMD_BOTH = 8'h42;

    // Byte idx of the ack frame: SOF, tag, mgu hi/lo, gnu hi/lo, EOF.
    function automatic logic [7:0] ack_frame_byte(
        input logic [2:0]  idx,
        input logic [7:0]  tag,
        input logic [15:0] mgu,
        input logic [15:0] gnu
    );
        case (idx)
            3'd0:    return ACK_SOF;
            3'd1:    return tag;
            3'd2:    return mgu[15:8];
            3'd3:    return mgu[7:0];
            3'd4:    return gnu[15:8];
            3'd5:    return gnu[7:0];
            default: return ACK_EOF;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 UART serialiser. o_done is high during the final cycle of
// the stop bit so a new i_start in that cycle continues with no idle gap.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  STOP_BIT = 4'd9;

    logic        busy_q;
    logic        tx_q;
    logic [7:0]  data_q;
    logic [3:0]  bit_q;
    logic [15:0] cnt_q;
    logic        bit_end;
    logic        last_cycle;

    assign bit_end    = busy_q && (cnt_q == CNT_LAST);
    assign last_cycle = bit_end && (bit_q == STOP_BIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            tx_q   <= 1'b1;
            data_q <= 8'h00;
            bit_q  <= 4'd0;
            cnt_q  <= 16'd0;
        end else if (i_start && (!busy_q || last_cycle)) begin
            busy_q <= 1'b1;
            tx_q   <= 1'b0;
            data_q <= i_byte;
            bit_q  <= 4'd0;
            cnt_q  <= 16'd0;
        end else if (bit_end) begin
            cnt_q <= 16'd0;
            if (bit_q == STOP_BIT) begin
                busy_q <= 1'b0;
                tx_q   <= 1'b1;
            end else begin
                // bit_q 0 is the start bit, so the next data bit is data_q[bit_q]
                bit_q <= bit_q + 4'd1;
                tx_q  <= (bit_q == 4'd8) ? 1'b1 : data_q[bit_q[2:0]];
            end
        end else if (busy_q) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = busy_q;
    assign o_done = last_cycle;

endmodule

// File: rtl/uart_cmd_ack.sv
// Latches interpreter commands, retires them with cmd_clear and, when
// UART_CMD_ACK_TX_EN is defined, sends a 7-byte 8N1 acknowledge frame.
module uart_cmd_ack
    import uart_cmd_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] ACK_TAG      = 8'h4B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] mgu_cmd,
    input  logic [15:0] gnu_cmd,
    input  logic        cmd_set,
    output logic        cmd_clear,
    output logic [15:0] mgu_out,
    output logic [15:0] gnu_out,
    output logic        cmd_strobe,
    output logic        oTx,
    output logic        tx_busy
);

    cmd_state_t  state_q, state_d;
    logic [15:0] mgu_out_q, gnu_out_q;
    logic        capture_pulse_q;
    logic        capture;

    assign capture = (state_q == ST_IDLE) && cmd_set;

`ifdef UART_CMD_ACK_TX_EN
    logic [2:0]  byte_idx_q;
    logic [2:0]  byte_idx_d;
    logic [15:0] snap_mgu_q, snap_gnu_q;
    logic        tx_start;
    logic        tx_done;
    logic [7:0]  tx_byte;

    // First byte launches on the DRAIN exit edge; later bytes chain off o_done.
    assign tx_start   = ((state_q == ST_DRAIN) && !cmd_set) ||
                        ((state_q == ST_SEND) && tx_done && (byte_idx_q != ACK_LAST_IDX));
    assign byte_idx_d = (state_q == ST_DRAIN) ? 3'd0 : byte_idx_q + 3'd1;
    assign tx_byte    = ack_frame_byte(byte_idx_d, ACK_TAG, snap_mgu_q, snap_gnu_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx_q <= 3'd0;
            snap_mgu_q <= 16'h0000;
            snap_gnu_q <= 16'h0000;
        end else begin
            if (capture) begin
                snap_mgu_q <= mgu_cmd;
                snap_gnu_q <= gnu_cmd;
            end
            if (tx_start) begin
                byte_idx_q <= byte_idx_d;
            end
        end
    end

    // The serialiser is busy exactly while the FSM is in SEND.
    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_start(tx_start),
        .i_byte (tx_byte),
        .o_tx   (oTx),
        .o_busy (tx_busy),
        .o_done (tx_done)
    );
`else
    assign oTx     = 1'b1;
    assign tx_busy = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (cmd_set) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_DRAIN;
`ifdef UART_CMD_ACK_TX_EN
            ST_DRAIN:   if (!cmd_set) state_d = ST_SEND;
            ST_SEND:    if (tx_done && (byte_idx_q == ACK_LAST_IDX)) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
`else
            ST_DRAIN:   if (!cmd_set) state_d = ST_IDLE;
`endif
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            mgu_out_q       <= 16'h0000;
            gnu_out_q       <= 16'h0000;
            capture_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            capture_pulse_q <= (state_q == ST_CAPTURE);
            if (capture) begin
                mgu_out_q <= mgu_cmd;
                gnu_out_q <= gnu_cmd;
            end
        end
    end

    assign mgu_out    = mgu_out_q;
    assign gnu_out    = gnu_out_q;
    assign cmd_strobe = capture_pulse_q;
    assign cmd_clear  = capture_pulse_q;

endmodule

// File: tb/tb_uart_cmd_ack.sv
// Directed bench for uart_cmd_ack at CLKS_PER_BIT=4; frame checks are active
// when UART_CMD_ACK_TX_EN is defined, otherwise the idle-line behaviour is checked.
module tb_uart_cmd_ack;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mgu_cmd = 16'h0000;
    logic [15:0] gnu_cmd = 16'h0000;
    logic        cmd_set = 1'b0;
    logic        cmd_clear;
    logic [15:0] mgu_out;
    logic [15:0] gnu_out;
    logic        cmd_strobe;
    logic        oTx;
    logic        tx_busy;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    uart_cmd_ack #(
        .CLKS_PER_BIT(CPB),
        .ACK_TAG     (8'h4B)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mgu_cmd   (mgu_cmd),
        .gnu_cmd   (gnu_cmd),
        .cmd_set   (cmd_set),
        .cmd_clear (cmd_clear),
        .mgu_out   (mgu_out),
        .gnu_out   (gnu_out),
        .cmd_strobe(cmd_strobe),
        .oTx       (oTx),
        .tx_busy   (tx_busy)
    );

    // Raise a command at a negedge; edge N captures it, strobe/clear expected at k=2.
    task automatic do_capture(input logic [15:0] m, input logic [15:0] g, input bit drop,
                              output int strobe_k, output int clear_k,
                              output int strobe_cnt, output int clear_cnt,
                              output logic [15:0] mo1, output logic [15:0] go1);
        strobe_k = 0; clear_k = 0; strobe_cnt = 0; clear_cnt = 0;
        mo1 = 16'h0; go1 = 16'h0;
        @(negedge clk);
        mgu_cmd = m; gnu_cmd = g; cmd_set = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) begin mo1 = mgu_out; go1 = gnu_out; end
            if (cmd_strobe === 1'b1) begin strobe_cnt++; if (strobe_k == 0) strobe_k = k; end
            if (cmd_clear === 1'b1) begin clear_cnt++; if (clear_k == 0) clear_k = k; end
            if (k == 3 && drop) cmd_set = 1'b0;
        end
    endtask

    // Samples one frame mid-bit; n=0 is the first negedge with the start bit low.
    task automatic decode_frame(input int stale_at, input int b2b_at,
                                output logic [55:0] frame, output int wait_cnt,
                                output int busy_cnt, output int framing_err,
                                output int clear_cnt);
        int j, b, p;
        frame = '0; wait_cnt = 0; busy_cnt = 0; framing_err = 0; clear_cnt = 0;
        for (int w = 1; w <= 20; w++) begin
            @(negedge clk);
            if (oTx === 1'b0) begin wait_cnt = w; break; end
        end
        if (wait_cnt == 0) return;
        for (int n = 0; n <= 281; n++) begin
            if (n > 0) @(negedge clk);
            if (n == stale_at) mgu_cmd = 16'hFFFF;
            if (n == b2b_at) begin mgu_cmd = 16'h0001; gnu_cmd = 16'h0002; cmd_set = 1'b1; end
            if (tx_busy === 1'b1) busy_cnt++;
            if (cmd_clear === 1'b1) clear_cnt++;
            if ((n % 4) == 1 && (n / 4) < 70) begin
                j = n / 4; b = j / 10; p = j % 10;
                if (p == 0) begin
                    if (oTx !== 1'b0) framing_err++;
                end else if (p == 9) begin
                    if (oTx !== 1'b1) framing_err++;
                end else begin
                    frame[48 - 8 * b + p - 1] = oTx;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_set = 1'b1; mgu_cmd = 16'h5555; gnu_cmd = 16'hAAAA;
        repeat (3) @(negedge clk);
        checks++; if (mgu_out !== 16'h0000) begin fails++; $display("FAIL reset_mgu_out: got %h expected %h", mgu_out, 16'h0000); end
        checks++; if (gnu_out !== 16'h0000) begin fails++; $display("FAIL reset_gnu_out: got %h expected %h", gnu_out, 16'h0000); end
        checks++; if (cmd_strobe !== 1'b0) begin fails++; $display("FAIL reset_strobe: got %b expected 0", cmd_strobe); end
        checks++; if (cmd_clear !== 1'b0) begin fails++; $display("FAIL reset_clear: got %b expected 0", cmd_clear); end
        checks++; if (oTx !== 1'b1) begin fails++; $display("FAIL reset_otx: got %b expected 1", oTx); end
        checks++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
        cmd_set = 1'b0; rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (mgu_out !== 16'h0000) begin fails++; $display("FAIL reset_wins_mgu: got %h expected %h", mgu_out, 16'h0000); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int sk, ck, sc, cc, wc, bc, fe, clr;
        logic [15:0] mo, go;
        logic [55:0] fr;
        do_capture(16'h1234, 16'hABCD, 1'b1, sk, ck, sc, cc, mo, go);
        checks++; if (mo !== 16'h1234) begin fails++; $display("FAIL single_mgu_out: got %h expected %h", mo, 16'h1234); end
        checks++; if (go !== 16'hABCD) begin fails++; $display("FAIL single_gnu_out: got %h expected %h", go, 16'hABCD); end
        checks++; if (sk != 2) begin fails++; $display("FAIL single_strobe_cycle: got %0d expected 2", sk); end
        checks++; if (ck != 2) begin fails++; $display("FAIL single_clear_cycle: got %0d expected 2", ck); end
        checks++; if (sc != 1) begin fails++; $display("FAIL single_strobe_width: got %0d expected 1", sc); end
        checks++; if (cc != 1) begin fails++; $display("FAIL single_clear_width: got %0d expected 1", cc); end
`ifdef UART_CMD_ACK_TX_EN
        decode_frame(-1, -1, fr, wc, bc, fe, clr);
        $display("single frame %h busy %0d", fr, bc);
        checks++; if (wc != 1) begin fails++; $display("FAIL single_frame_start: got %0d expected 1", wc); end
        checks++; if (fr !== 56'h214B1234ABCD0D) begin fails++; $display("FAIL single_frame: got %h expected %h", fr, 56'h214B1234ABCD0D); end
        checks++; if (bc != 280) begin fails++; $display("FAIL single_busy_cycles: got %0d expected 280", bc); end
        checks++; if (fe != 0) begin fails++; $display("FAIL single_framing: got %0d expected 0", fe); end
`else
        wc = 0; bc = 0; fr = '0; fe = 0; clr = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (oTx !== 1'b1) wc++;
            if (tx_busy !== 1'b0) bc++;
        end
        $display("single no-tx: otx_low %0d busy %0d", wc, bc);
        checks++; if (wc != 0) begin fails++; $display("FAIL notx_otx_low: got %0d expected 0", wc); end
        checks++; if (bc != 0) begin fails++; $display("FAIL notx_busy: got %0d expected 0", bc); end
`endif
    endtask

    task automatic test_stale();
        int sk, ck, sc, cc, wc, bc, fe, clr;
        logic [15:0] mo, go;
        logic [55:0] fr;
        do_capture(16'h1234, 16'h5678, 1'b1, sk, ck, sc, cc, mo, go);
`ifdef UART_CMD_ACK_TX_EN
        decode_frame(40, -1, fr, wc, bc, fe, clr);
        $display("stale frame %h", fr);
        checks++; if (fr !== 56'h214B12345678_0D) begin fails++; $display("FAIL stale_frame: got %h expected %h", fr, 56'h214B123456780D); end
`else
        @(negedge clk);
        mgu_cmd = 16'hFFFF;
        repeat (10) @(negedge clk);
        $display("stale mgu_out %h", mgu_out);
`endif
        checks++; if (mgu_out !== 16'h1234) begin fails++; $display("FAIL stale_mgu_out: got %h expected %h", mgu_out, 16'h1234); end
        checks++; if (gnu_out !== 16'h5678) begin fails++; $display("FAIL stale_gnu_out: got %h expected %h", gnu_out, 16'h5678); end
    endtask

    task automatic test_back_to_back();
        int sk, ck, sc, cc, wc, bc, fe, clr, first_clear;
        logic [15:0] mo, go;
        logic [55:0] fr;
        do_capture(16'hC0DE, 16'h0BAD, 1'b1, sk, ck, sc, cc, mo, go);
`ifdef UART_CMD_ACK_TX_EN
        decode_frame(-1, 100, fr, wc, bc, fe, clr);
        $display("b2b frame1 %h", fr);
        checks++; if (fr !== 56'h214BC0DE0BAD0D) begin fails++; $display("FAIL b2b_frame1: got %h expected %h", fr, 56'h214BC0DE0BAD0D); end
        checks++; if (clr != 0) begin fails++; $display("FAIL b2b_early_clear: got %0d expected 0", clr); end
        first_clear = 0;
        for (int n = 282; n <= 300; n++) begin
            @(negedge clk);
            if (cmd_clear === 1'b1) begin
                first_clear = n;
                @(negedge clk);
                cmd_set = 1'b0;
                break;
            end
        end
        checks++; if (first_clear != 283) begin fails++; $display("FAIL b2b_clear_cycle: got %0d expected 283", first_clear); end
        checks++; if (mgu_out !== 16'h0001) begin fails++; $display("FAIL b2b_mgu_out: got %h expected %h", mgu_out, 16'h0001); end
        checks++; if (gnu_out !== 16'h0002) begin fails++; $display("FAIL b2b_gnu_out: got %h expected %h", gnu_out, 16'h0002); end
        cmd_set = 1'b0;
        decode_frame(-1, -1, fr, wc, bc, fe, clr);
        $display("b2b frame2 %h", fr);
        checks++; if (wc != 1) begin fails++; $display("FAIL b2b_frame2_start: got %0d expected 1", wc); end
        checks++; if (fr !== 56'h214B000100020D) begin fails++; $display("FAIL b2b_frame2: got %h expected %h", fr, 56'h214B000100020D); end
`else
        // DRAIN returns straight to IDLE, so an immediate second command is captured on time.
        do_capture(16'h0001, 16'h0002, 1'b1, sk, ck, sc, cc, mo, go);
        $display("b2b second capture strobe at %0d", sk);
        checks++; if (sk != 2) begin fails++; $display("FAIL b2b_second_strobe: got %0d expected 2", sk); end
        checks++; if (mo !== 16'h0001) begin fails++; $display("FAIL b2b_mgu_out: got %h expected %h", mo, 16'h0001); end
        checks++; if (go !== 16'h0002) begin fails++; $display("FAIL b2b_gnu_out: got %h expected %h", go, 16'h0002); end
        repeat (2) @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid_frame();
        int sk, ck, sc, cc, lows, busy, strobes, w;
        logic [15:0] mo, go;
        do_capture(16'h1234, 16'hABCD, 1'b1, sk, ck, sc, cc, mo, go);
`ifdef UART_CMD_ACK_TX_EN
        w = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (oTx === 1'b0) begin w = i; break; end
        end
        repeat (80) @(negedge clk);
        checks++; if (oTx !== 1'b0) begin fails++; $display("FAIL midrst_pre_otx: got %b expected 0", oTx); end
`else
        repeat (5) @(negedge clk);
`endif
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (oTx !== 1'b1) begin fails++; $display("FAIL midrst_otx: got %b expected 1", oTx); end
        checks++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", tx_busy); end
        checks++; if (mgu_out !== 16'h0000) begin fails++; $display("FAIL midrst_mgu_out: got %h expected %h", mgu_out, 16'h0000); end
        checks++; if (gnu_out !== 16'h0000) begin fails++; $display("FAIL midrst_gnu_out: got %h expected %h", gnu_out, 16'h0000); end
        rst_n = 1'b1;
        lows = 0; busy = 0; strobes = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (oTx !== 1'b1) lows++;
            if (tx_busy !== 1'b0) busy++;
            if (cmd_strobe !== 1'b0) strobes++;
        end
        $display("reset mid-frame: otx_low %0d busy %0d strobes %0d", lows, busy, strobes);
        checks++; if (lows != 0) begin fails++; $display("FAIL midrst_quiet_otx: got %0d expected 0", lows); end
        checks++; if (busy != 0) begin fails++; $display("FAIL midrst_quiet_busy: got %0d expected 0", busy); end
    endtask

    task automatic test_cmd_stuck();
        int sk, ck, sc, cc, lows, busy, strobes;
        logic [15:0] mo, go;
        do_capture(16'h2222, 16'h3333, 1'b0, sk, ck, sc, cc, mo, go);
        lows = 0; busy = 0; strobes = sc;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (oTx !== 1'b1) lows++;
            if (tx_busy !== 1'b0) busy++;
            if (cmd_strobe === 1'b1) strobes++;
        end
        $display("stuck cmd_set: strobes %0d otx_low %0d busy %0d", strobes, lows, busy);
        checks++; if (strobes != 1) begin fails++; $display("FAIL stuck_strobes: got %0d expected 1", strobes); end
        checks++; if (lows != 0) begin fails++; $display("FAIL stuck_otx: got %0d expected 0", lows); end
        checks++; if (busy != 0) begin fails++; $display("FAIL stuck_busy: got %0d expected 0", busy); end
        cmd_set = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_stale();
        test_back_to_back();
        test_reset_mid_frame();
        test_cmd_stuck();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
